// File: rtl/jt49_noise_seq.sv
// Noise period sequencer: holds a fixed period or ramps it between two values on the cen time base.
// Optional ping-pong mode 3 is enabled by defining JT49_NOISE_SEQ_PINGPONG_EN.
module jt49_noise_seq #(
   parameter int unsigned PW    = 5,
   parameter int unsigned STEPW = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cen,
   input  logic             cfg_we,
   input  logic [PW-1:0]    cfg_start,
   input  logic [PW-1:0]    cfg_end,
   input  logic [7:0]       cfg_rate,
   input  logic [STEPW-1:0] cfg_step,
   input  logic [1:0]       cfg_mode,
   output logic [PW-1:0]    period,
   output logic             busy,
   output logic             done
);

   typedef enum logic {StIdle, StRun} state_t;

   state_t           state;
   logic [PW-1:0]    start_q, end_q;
   logic [7:0]       rate_q, presc;
   logic [STEPW-1:0] step_q;
   logic [1:0]       mode_q;
   logic             dir_up;
   logic             wrap_pend;   // mode 2: next step tick jumps back to start

   logic [PW-1:0] target;
`ifdef JT49_NOISE_SEQ_PINGPONG_EN
   logic [PW-1:0] tgt_q;
   assign target = tgt_q;
`else
   assign target = end_q;
`endif

   logic          ramp_mode;
   logic [PW:0]   step_ext, sum, diff;
   logic [PW-1:0] next_up, next_dn, step_val;
   logic          hit;

   always_comb begin
`ifdef JT49_NOISE_SEQ_PINGPONG_EN
      ramp_mode = cfg_mode != 2'd0;
`else
      ramp_mode = (cfg_mode == 2'd1) || (cfg_mode == 2'd2);
`endif
      step_ext = (step_q == '0) ? (PW+1)'(1) : (PW+1)'(step_q);
      sum      = {1'b0, period} + step_ext;
      diff     = {1'b0, period} - step_ext;
      // Saturate at the target so the ramp never overshoots or wraps
      next_up  = (sum >= {1'b0, target}) ? target : sum[PW-1:0];
      next_dn  = (diff[PW] || (diff[PW-1:0] <= target)) ? target : diff[PW-1:0];
      step_val = dir_up ? next_up : next_dn;
      hit      = step_val == target;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         period    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         presc     <= '0;
         start_q   <= '0;
         end_q     <= '0;
         rate_q    <= '0;
         step_q    <= '0;
         mode_q    <= '0;
         dir_up    <= 1'b0;
         wrap_pend <= 1'b0;
`ifdef JT49_NOISE_SEQ_PINGPONG_EN
         tgt_q     <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (cfg_we) begin
            start_q   <= cfg_start;
            end_q     <= cfg_end;
            rate_q    <= cfg_rate;
            step_q    <= cfg_step;
            mode_q    <= cfg_mode;
            period    <= cfg_start;
            presc     <= cfg_rate;
            dir_up    <= cfg_end > cfg_start;
            wrap_pend <= 1'b0;
`ifdef JT49_NOISE_SEQ_PINGPONG_EN
            tgt_q     <= cfg_end;
`endif
            if (ramp_mode && (cfg_start != cfg_end)) begin
               state <= StRun;
               busy  <= 1'b1;
            end else begin
               state <= StIdle;
               busy  <= 1'b0;
            end
            done <= ramp_mode && (cfg_start == cfg_end) && !done;
         end else if (state == StRun && cen) begin
            if (presc != '0) begin
               presc <= presc - 8'd1;
            end else begin
               presc <= rate_q;
               if (wrap_pend) begin
                  period    <= start_q;
                  wrap_pend <= 1'b0;
               end else begin
                  period <= step_val;
                  if (hit) begin
                     done <= !done;
                     case (mode_q)
                        2'd1: begin
                           state <= StIdle;
                           busy  <= 1'b0;
                        end
                        2'd2: wrap_pend <= 1'b1;
`ifdef JT49_NOISE_SEQ_PINGPONG_EN
                        2'd3: begin
                           dir_up <= !dir_up;
                           tgt_q  <= (tgt_q == end_q) ? start_q : end_q;
                        end
`endif
                        default: ;
                     endcase
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_jt49_noise_seq.sv
// Table-driven directed bench for jt49_noise_seq; define JT49_NOISE_SEQ_PINGPONG_EN to cover mode 3.
module tb_jt49_noise_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cen;
   logic       cfg_we;
   logic [4:0] cfg_start, cfg_end;
   logic [7:0] cfg_rate;
   logic [2:0] cfg_step;
   logic [1:0] cfg_mode;
   logic [4:0] period;
   logic       busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   jt49_noise_seq #(.PW(5), .STEPW(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cen       (cen),
      .cfg_we    (cfg_we),
      .cfg_start (cfg_start),
      .cfg_end   (cfg_end),
      .cfg_rate  (cfg_rate),
      .cfg_step  (cfg_step),
      .cfg_mode  (cfg_mode),
      .period    (period),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic       cen;
      logic [4:0] start;
      logic [4:0] fin;
      logic [7:0] rate;
      logic [2:0] step;
      logic [1:0] mode;
      logic [4:0] exp_period;
      logic       exp_busy;
      logic       exp_done;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic we, input logic c, input int s, input int e, input int r,
                      input int st, input int m, input int ep, input logic eb, input logic ed);
      vec_t v;
      v.we = we; v.cen = c; v.start = 5'(s); v.fin = 5'(e); v.rate = 8'(r);
      v.step = 3'(st); v.mode = 2'(m); v.exp_period = 5'(ep); v.exp_busy = eb; v.exp_done = ed;
      vecs.push_back(v);
   endtask

   // Idle cycle with cen high and no config write
   task automatic tick(input int ep, input logic eb, input logic ed);
      add(1'b0, 1'b1, 0, 0, 0, 0, 0, ep, eb, ed);
   endtask

   task automatic check(input string name, input int idx, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp_v);
      end
   endtask

   task automatic drive(input logic we, input logic c, input logic [4:0] s, input logic [4:0] e,
                        input logic [7:0] r, input logic [2:0] st, input logic [1:0] m);
      @(negedge clk);
      cfg_we = we; cen = c; cfg_start = s; cfg_end = e; cfg_rate = r; cfg_step = st; cfg_mode = m;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; cen = 1'b0; cfg_we = 1'b0;
      cfg_start = '0; cfg_end = '0; cfg_rate = '0; cfg_step = '0; cfg_mode = '0;

      // Test 2: single up ramp, rate 1 -> change every 2 clks
      add(1, 1, 2, 10, 1, 3, 1,  2, 1, 0);
      tick(2, 1, 0); tick(5, 1, 0); tick(5, 1, 0); tick(8, 1, 0); tick(8, 1, 0);
      tick(10, 0, 1); tick(10, 0, 0); tick(10, 0, 0);
      // Test 3: down ramp saturating at 1, cen frozen mid-ramp
      add(1, 1, 20, 1, 0, 7, 1, 20, 1, 0);
      tick(13, 1, 0);
      for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 0, 13, 1, 0);
      tick(6, 1, 0); tick(1, 0, 1); tick(1, 0, 0);
      // Test 4: repeat ramp
      add(1, 1, 4, 6, 0, 1, 2, 4, 1, 0);
      tick(5, 1, 0); tick(6, 1, 1); tick(4, 1, 0); tick(5, 1, 0); tick(6, 1, 1); tick(4, 1, 0);
      // Test 5: abort on a step tick, then cfg_we coincident with a step tick
      add(1, 1, 0, 20, 0, 5, 1, 0, 1, 0);
      tick(5, 1, 0);
      add(1, 1, 31, 0, 0, 1, 0, 31, 0, 0);
      tick(31, 0, 0);
      add(1, 1, 0, 20, 0, 5, 1, 0, 1, 0);
      add(1, 1, 8, 20, 0, 5, 1, 8, 1, 0);
      tick(13, 1, 0);
      // start == end in a ramp mode: immediate done, stays idle
      add(1, 1, 9, 9, 0, 1, 1, 9, 0, 1);
      tick(9, 0, 0);
      // step 0 acts as 1, downward
      add(1, 1, 30, 28, 0, 0, 1, 30, 1, 0);
      tick(29, 1, 0); tick(28, 0, 1);
      // Test 6: mode 3
`ifdef JT49_NOISE_SEQ_PINGPONG_EN
      add(1, 1, 3, 5, 0, 1, 3, 3, 1, 0);
      tick(4, 1, 0); tick(5, 1, 1); tick(4, 1, 0); tick(3, 1, 1); tick(4, 1, 0); tick(5, 1, 1);
      tick(4, 1, 0);
`else
      add(1, 1, 3, 5, 0, 1, 3, 3, 0, 0);
      tick(3, 0, 0); tick(3, 0, 0); tick(3, 0, 0);
`endif

      // Reset state
      #12;
      check("reset period", 0, int'(period), 0);
      check("reset busy", 0, int'(busy), 0);
      check("reset done", 0, int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Test 1: fixed mode holds start, never pulses done
      drive(1'b1, 1'b1, 5'd7, 5'd20, 8'd0, 3'd1, 2'd0);
      check("t1 period", 0, int'(period), 7);
      check("t1 busy", 0, int'(busy), 0);
      for (int i = 0; i < 100; i++) begin
         drive(1'b0, 1'b1, 5'd0, 5'd0, 8'd0, 3'd0, 2'd0);
         check("t1 done", i, int'(done), 0);
      end
      check("t1 period held", 0, int'(period), 7);

      foreach (vecs[i]) begin
         drive(vecs[i].we, vecs[i].cen, vecs[i].start, vecs[i].fin, vecs[i].rate,
               vecs[i].step, vecs[i].mode);
         check("vec period", i, int'(period), int'(vecs[i].exp_period));
         check("vec busy", i, int'(busy), int'(vecs[i].exp_busy));
         check("vec done", i, int'(done), int'(vecs[i].exp_done));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
